pe_db: RTL and testbench

PE_DB -- requirements
Module: pe_db

---
 rtl/pe_db.sv | 186 ++++++++++++++++++
 tb/tb_pe_db.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_db.sv
// pe_db: weight-stationary multiply-accumulate processing element for a
// systolic array. Weights are double-buffered: a shadow register is loaded
// from the a bus while the active weight keeps computing. A swap strobe then
// promotes the shadow weight to active. Each issued beat produces
// o_c = i_c + i_a * active_weight, with wrap or saturation on overflow.
module pe_db #(
    parameter int X_WIDTH  = 16,
    parameter int Y_WIDTH  = 2*X_WIDTH,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0,
    parameter int PIPE     = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_we,
    output logic               o_we,
    input  logic               i_swap,
    output logic               o_swap,
    input  logic               i_a_vld,
    input  logic [X_WIDTH-1:0] i_a,
    output logic               o_a_vld,
    output logic [X_WIDTH-1:0] o_a,
    input  logic               i_c_vld,
    input  logic [Y_WIDTH-1:0] i_c,
    output logic               o_c_vld,
    output logic [Y_WIDTH-1:0] o_c,
    output logic               o_ovf
);

    // Overflow of the Y_WIDTH+1 bit sum: a carry out for unsigned data, or
    // disagreement between the true sign bit and the Y_WIDTH result sign.
    function automatic logic ovf_detect(input logic [Y_WIDTH:0] s);
        if (SIGNED != 0) begin
            return s[Y_WIDTH] ^ s[Y_WIDTH-1];
        end
        return s[Y_WIDTH];
    endfunction

    // Wrap keeps the low bits; saturation clamps toward the true sign.
    function automatic logic [Y_WIDTH-1:0] saturate(input logic [Y_WIDTH:0] s,
                                                    input logic           ovf);
        if (!ovf || (SATURATE == 0)) begin
            return s[Y_WIDTH-1:0];
        end
        if (SIGNED == 0) begin
            return '1;
        end
        return s[Y_WIDTH] ? {1'b1, {(Y_WIDTH-1){1'b0}}}
                          : {1'b0, {(Y_WIDTH-1){1'b1}}};
    endfunction

    logic [X_WIDTH-1:0]            shadow_w;
    logic [X_WIDTH-1:0]            active_w;
    logic                          shadow_vld;
    logic                          active_vld;
    logic                          issue;
    logic signed [2*X_WIDTH-1:0]   a_ext;
    logic signed [2*X_WIDTH-1:0]   w_ext;
    logic signed [2*X_WIDTH-1:0]   mul_p0;
    logic [Y_WIDTH-1:0]            prod_p0;
    logic [Y_WIDTH-1:0]            add_prod;
    logic [Y_WIDTH-1:0]            add_c;
    logic                          add_vld;
    logic [Y_WIDTH:0]              sum;
    logic                          sum_ovf;

    // A weight-load beat carries weight data on the a bus, so it never issues.
    assign issue = i_a_vld & i_c_vld & ~i_we;

    // Forward the row operand and control strobes to the neighbouring PE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_a     <= '0;
            o_a_vld <= 1'b0;
            o_we    <= 1'b0;
            o_swap  <= 1'b0;
        end else begin
            o_a     <= i_a;
            o_a_vld <= i_a_vld;
            o_we    <= i_we;
            o_swap  <= i_swap;
        end
    end

    // Shadow/active weights: swap reads the pre-edge shadow, so a load on the
    // same edge lands in shadow and leaves it valid for the next swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_w   <= '0;
            shadow_vld <= 1'b0;
            active_w   <= '0;
            active_vld <= 1'b0;
        end else begin
            if (i_swap) begin
                active_w   <= shadow_w;
                active_vld <= shadow_vld;
            end
            if (i_we && i_a_vld) begin
                shadow_w   <= i_a;
                shadow_vld <= 1'b1;
            end else if (i_swap) begin
                shadow_vld <= 1'b0;
            end
        end
    end

    // Stage 0: extend operands to 2*X_WIDTH so the product cannot overflow.
    always_comb begin
        a_ext = '0;
        w_ext = '0;
        a_ext[X_WIDTH-1:0] = i_a;
        w_ext[X_WIDTH-1:0] = active_w;
        if (SIGNED != 0) begin
            for (int i = X_WIDTH; i < 2*X_WIDTH; i++) begin
                a_ext[i] = i_a[X_WIDTH-1];
                w_ext[i] = active_w[X_WIDTH-1];
            end
        end
    end

    assign mul_p0 = a_ext * w_ext;

    // Extend the product to the partial-sum width; no valid weight means
    // the incoming partial sum passes through untouched.
    always_comb begin
        prod_p0 = '0;
        if (active_vld) begin
            prod_p0[2*X_WIDTH-1:0] = mul_p0;
            for (int i = 2*X_WIDTH; i < Y_WIDTH; i++) begin
                prod_p0[i] = (SIGNED != 0) ? mul_p0[2*X_WIDTH-1] : 1'b0;
            end
        end
    end

    if (PIPE != 0) begin : g_pipe
        logic [Y_WIDTH-1:0] prod_p1;
        logic [Y_WIDTH-1:0] c_p1;
        logic               vld_p1;

        // Stage 1: register the product and partial sum ahead of the adder.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                prod_p1 <= '0;
                c_p1    <= '0;
                vld_p1  <= 1'b0;
            end else begin
                vld_p1 <= issue;
                if (issue) begin
                    prod_p1 <= prod_p0;
                    c_p1    <= i_c;
                end
            end
        end

        assign add_prod = prod_p1;
        assign add_c    = c_p1;
        assign add_vld  = vld_p1;
    end else begin : g_comb
        assign add_prod = prod_p0;
        assign add_c    = i_c;
        assign add_vld  = issue;
    end

    // Final stage: one-bit-wider add so overflow is visible in the sum.
    always_comb begin
        sum = {(SIGNED != 0) & add_prod[Y_WIDTH-1], add_prod}
            + {(SIGNED != 0) & add_c[Y_WIDTH-1], add_c};
        sum_ovf = ovf_detect(sum);
    end

    // Output register: o_c/o_ovf only change on a valid beat and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_c_vld <= 1'b0;
            o_c     <= '0;
            o_ovf   <= 1'b0;
        end else begin
            o_c_vld <= add_vld;
            if (add_vld) begin
                o_c   <= saturate(sum, sum_ovf);
                o_ovf <= sum_ovf;
            end
        end
    end

endmodule

// File: tb/tb_pe_db.sv
// tb_pe_db: four pe_db instances (X=8, Y=16) share one stimulus stream and
// differ in SIGNED / SATURATE / PIPE. A directed table, a randomized phase and
// a mid-pipeline reset sequence are checked against an arithmetic model.
module tb_pe_db;

    localparam bit [3:0] SGN = 4'b1100;
    localparam bit [3:0] SAT = 4'b0110;
    localparam bit [3:0] PIP = 4'b1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic        sw = 1'b0;
    logic        av = 1'b0;
    logic [7:0]  a = '0;
    logic        cv = 1'b0;
    logic [15:0] c = '0;

    logic        owe [4];
    logic        oswap [4];
    logic        oav [4];
    logic [7:0]  oa [4];
    logic        ocv [4];
    logic [15:0] oc [4];
    logic        oovf [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        pe_db #(
            .X_WIDTH (8),
            .Y_WIDTH (16),
            .SIGNED  (SGN[g] ? 1 : 0),
            .SATURATE(SAT[g] ? 1 : 0),
            .PIPE    (PIP[g] ? 1 : 0)
        ) dut (
            .clk    (clk),
            .rst    (rst),
            .i_we   (we),
            .o_we   (owe[g]),
            .i_swap (sw),
            .o_swap (oswap[g]),
            .i_a_vld(av),
            .i_a    (a),
            .o_a_vld(oav[g]),
            .o_a    (oa[g]),
            .i_c_vld(cv),
            .i_c    (c),
            .o_c_vld(ocv[g]),
            .o_c    (oc[g]),
            .o_ovf  (oovf[g])
        );
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", name, k, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [15:0] c;
        logic        ovf;
    } beat_t;

    beat_t       pq [4][$];
    logic [7:0]  m_shadow, m_active;
    logic        m_svld, m_avld;
    logic [15:0] h_c [4];
    logic        h_ovf [4];
    logic        e_vld [4];
    logic [7:0]  e_a;
    logic        e_av, e_we, e_swap;
    int          n_edge = 0;

    function automatic void calc(input int k, input logic [7:0] x, input logic [7:0] w,
                                 input logic wv, input logic [15:0] cin,
                                 output logic [15:0] res, output logic of);
        longint pa, pw, pc, s, lo, hi;
        pa = longint'(x);
        pw = longint'(w);
        pc = longint'(cin);
        if (SGN[k]) begin
            if (x[7])    pa -= 256;
            if (w[7])    pw -= 256;
            if (cin[15]) pc -= 65536;
            lo = -32768;
            hi = 32767;
        end else begin
            lo = 0;
            hi = 65535;
        end
        s = (wv ? pa * pw : longint'(0)) + pc;
        of = (s > hi) || (s < lo);
        if (of && SAT[k]) s = (s > hi) ? hi : lo;
        res = s[15:0];
    endfunction

    task automatic model_reset();
        m_shadow = '0;
        m_active = '0;
        m_svld   = 1'b0;
        m_avld   = 1'b0;
        e_a      = '0;
        e_av     = 1'b0;
        e_we     = 1'b0;
        e_swap   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pq[k].delete();
            h_c[k]   = '0;
            h_ovf[k] = 1'b0;
            e_vld[k] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic we_, input logic sw_, input logic av_,
                              input logic [7:0] a_, input logic cv_, input logic [15:0] c_);
        logic [15:0] r;
        logic        o;
        logic [7:0]  old_sh;
        logic        old_sv;
        n_edge++;
        if (av_ && cv_ && !we_) begin
            for (int k = 0; k < 4; k++) begin
                calc(k, a_, m_active, m_avld, c_, r, o);
                pq[k].push_back('{due: n_edge + (PIP[k] ? 1 : 0), c: r, ovf: o});
            end
        end
        old_sh = m_shadow;
        old_sv = m_svld;
        if (we_ && av_) begin
            m_shadow = a_;
            m_svld   = 1'b1;
        end else if (sw_) begin
            m_svld = 1'b0;
        end
        if (sw_) begin
            m_active = old_sh;
            m_avld   = old_sv;
        end
        for (int k = 0; k < 4; k++) begin
            e_vld[k] = 1'b0;
            if (pq[k].size() > 0 && pq[k][0].due == n_edge) begin
                e_vld[k] = 1'b1;
                h_c[k]   = pq[k][0].c;
                h_ovf[k] = pq[k][0].ovf;
                void'(pq[k].pop_front());
            end
        end
        e_a    = a_;
        e_av   = av_;
        e_we   = we_;
        e_swap = sw_;
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            chk("o_c_vld", k, 32'(ocv[k]),   32'(e_vld[k]));
            chk("o_c",     k, 32'(oc[k]),    32'(h_c[k]));
            chk("o_ovf",   k, 32'(oovf[k]),  32'(h_ovf[k]));
            chk("o_a",     k, 32'(oa[k]),    32'(e_a));
            chk("o_a_vld", k, 32'(oav[k]),   32'(e_av));
            chk("o_we",    k, 32'(owe[k]),   32'(e_we));
            chk("o_swap",  k, 32'(oswap[k]), 32'(e_swap));
        end
    endtask

    // Called at posedge+1: samples current inputs across the next edge.
    task automatic step();
        logic we_c, sw_c, av_c, cv_c;
        logic [7:0]  a_c;
        logic [15:0] c_c;
        we_c = we; sw_c = sw; av_c = av; a_c = a; cv_c = cv; c_c = c;
        @(posedge clk);
        #1;
        model_edge(we_c, sw_c, av_c, a_c, cv_c, c_c);
        check_all();
    endtask

    // Asserts rst mid-cycle, checks the asynchronous clear, holds over one edge.
    task automatic do_reset();
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        we, sw, av;
        logic [7:0]  a;
        logic        cv;
        logic [15:0] c;
        logic        ev;
        logic [15:0] ec0, ec1, ec2;
        logic [2:0]  eo;
    } vec_t;

    vec_t tv [24];

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        int post;
        //          we sw av a      cv c         ev ec0       ec1       ec2       eo
        tv[0]  = '{0, 0, 1, 8'hFF, 1, 16'h1234, 1, 16'h1234, 16'h1234, 16'h1234, 3'b000};
        tv[1]  = '{1, 0, 1, 8'h03, 1, 16'h5555, 0, 16'h1234, 16'h1234, 16'h1234, 3'b000};
        tv[2]  = '{0, 1, 0, 8'h00, 0, 16'h0000, 0, 16'h1234, 16'h1234, 16'h1234, 3'b000};
        tv[3]  = '{0, 0, 1, 8'h05, 1, 16'h0007, 1, 16'h0016, 16'h0016, 16'h0016, 3'b000};
        tv[4]  = '{0, 1, 1, 8'h04, 1, 16'h0000, 1, 16'h000C, 16'h000C, 16'h000C, 3'b000};
        tv[5]  = '{0, 0, 1, 8'h09, 1, 16'h0100, 1, 16'h0100, 16'h0100, 16'h0100, 3'b000};
        tv[6]  = '{1, 0, 1, 8'h02, 0, 16'h0000, 0, 16'h0100, 16'h0100, 16'h0100, 3'b000};
        tv[7]  = '{0, 1, 0, 8'h00, 0, 16'h0000, 0, 16'h0100, 16'h0100, 16'h0100, 3'b000};
        tv[8]  = '{1, 0, 1, 8'h03, 0, 16'h0000, 0, 16'h0100, 16'h0100, 16'h0100, 3'b000};
        tv[9]  = '{0, 0, 1, 8'h04, 1, 16'h0000, 1, 16'h0008, 16'h0008, 16'h0008, 3'b000};
        tv[10] = '{1, 1, 1, 8'h09, 1, 16'h0000, 0, 16'h0008, 16'h0008, 16'h0008, 3'b000};
        tv[11] = '{0, 0, 1, 8'h04, 1, 16'h0000, 1, 16'h000C, 16'h000C, 16'h000C, 3'b000};
        tv[12] = '{0, 1, 0, 8'h00, 0, 16'h0000, 0, 16'h000C, 16'h000C, 16'h000C, 3'b000};
        tv[13] = '{0, 0, 1, 8'h01, 1, 16'h0000, 1, 16'h0009, 16'h0009, 16'h0009, 3'b000};
        tv[14] = '{1, 0, 1, 8'hFF, 0, 16'h0000, 0, 16'h0009, 16'h0009, 16'h0009, 3'b000};
        tv[15] = '{0, 1, 0, 8'h00, 0, 16'h0000, 0, 16'h0009, 16'h0009, 16'h0009, 3'b000};
        tv[16] = '{0, 0, 1, 8'hFF, 1, 16'h8000, 1, 16'h7E01, 16'hFFFF, 16'h8001, 3'b011};
        tv[17] = '{0, 0, 1, 8'h01, 1, 16'hFFFF, 1, 16'h00FE, 16'hFFFF, 16'hFFFE, 3'b011};
        tv[18] = '{0, 0, 1, 8'h01, 0, 16'hFFFF, 0, 16'h00FE, 16'hFFFF, 16'hFFFE, 3'b011};
        tv[19] = '{1, 0, 1, 8'h80, 0, 16'h0000, 0, 16'h00FE, 16'hFFFF, 16'hFFFE, 3'b011};
        tv[20] = '{0, 1, 0, 8'h00, 0, 16'h0000, 0, 16'h00FE, 16'hFFFF, 16'hFFFE, 3'b011};
        tv[21] = '{0, 0, 1, 8'h80, 1, 16'h7FFF, 1, 16'hBFFF, 16'hBFFF, 16'h7FFF, 3'b100};
        tv[22] = '{0, 0, 1, 8'h80, 1, 16'h8000, 1, 16'hC000, 16'hC000, 16'hC000, 3'b000};
        tv[23] = '{0, 0, 1, 8'h7F, 1, 16'h8000, 1, 16'hBF80, 16'hBF80, 16'h8000, 3'b100};

        // Power-on reset: outputs must clear asynchronously.
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            we = tv[i].we; sw = tv[i].sw; av = tv[i].av;
            a  = tv[i].a;  cv = tv[i].cv; c  = tv[i].c;
            step();
            chk("tab_vld",  i, 32'(ocv[0]),  32'(tv[i].ev));
            chk("tab_c0",   i, 32'(oc[0]),   32'(tv[i].ec0));
            chk("tab_c1",   i, 32'(oc[1]),   32'(tv[i].ec1));
            chk("tab_c2",   i, 32'(oc[2]),   32'(tv[i].ec2));
            chk("tab_ovf0", i, 32'(oovf[0]), 32'(tv[i].eo[0]));
            chk("tab_ovf1", i, 32'(oovf[1]), 32'(tv[i].eo[1]));
            chk("tab_ovf2", i, 32'(oovf[2]), 32'(tv[i].eo[2]));
        end

        // Randomized traffic with extreme operands and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            we = ($urandom_range(0, 4) == 0);
            sw = ($urandom_range(0, 5) == 0);
            av = ($urandom_range(0, 3) != 0);
            cv = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       a = 8'h80;
                1:       a = 8'hFF;
                default: a = 8'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0:       c = 16'h7FFF;
                1:       c = 16'h8000;
                2:       c = 16'hFFFF;
                default: c = 16'($urandom);
            endcase
            if ($urandom_range(0, 199) == 0) do_reset();
            else step();
        end

        // Reset in the middle of back-to-back issues on the registered-product PE.
        we = 1'b0; sw = 1'b0; av = 1'b0; cv = 1'b0; a = '0; c = '0;
        do_reset();
        we = 1'b1; av = 1'b1; a = 8'h05;
        step();
        we = 1'b0; av = 1'b0; sw = 1'b1;
        step();
        sw = 1'b0; av = 1'b1; cv = 1'b1; a = 8'h03; c = 16'h0001;
        pulses = 0;
        step();
        if (ocv[3]) pulses++;
        a = 8'h04;
        step();
        if (ocv[3]) pulses++;
        chk("pipe_first_beat", 3, 32'(oc[3]), 32'h0010);
        a = 8'h06;
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 a = 8'h07;
        @(posedge clk);
        #1;
        av = 1'b0; cv = 1'b0; rst = 1'b0;
        check_all();
        post = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ocv[3]) post++;
        end
        chk("pulses_before_rst", 3, 32'(pulses), 32'd1);
        chk("pulses_after_rst",  3, 32'(post),   32'd0);
        chk("o_c_after_rst",     3, 32'(oc[3]),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
